// File: rtl/ifetch_prefetch_buf_pkg.sv
// Shared encodings for the instruction prefetch buffer: FSM states and the NOP word
// presented to the CPU while the fetch port is not ready.
package ifetch_prefetch_buf_pkg;

  typedef enum logic [1:0] {
    IFB_IDLE  = 2'd0,
    IFB_FETCH = 2'd1,
    IFB_DRAIN = 2'd2
  } ifb_state_e;

  localparam logic [31:0] IFB_NOP = 32'h0000_0000;

endpackage

// File: rtl/ifetch_prefetch_buf_fifo.sv
// Circular DEPTH x DW word buffer with push, pop, flush and an occupancy count.
// The head word is always visible on rdata.
module ifetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DW-1:0]                wdata,
  output logic [DW-1:0]                rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DW-1:0] ram [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) ram[wr_ptr] <= wdata;
  end

  assign rdata = ram[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/ifetch_prefetch_buf.sv
// Instruction prefetch queue between the CPU fetch port and a handshaked memory.
// Optional performance counters are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_prefetch_buf #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_en,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_ready,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
);

  import ifetch_prefetch_buf_pkg::*;

  localparam int unsigned CW   = $clog2(DEPTH+1);
  localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);

  ifb_state_e    state;
  ifb_state_e    state_next;
  logic [AW-1:0] head_addr;
  logic [AW-1:0] head_addr_next;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] fetch_addr_next;
  logic [AW-1:0] mem_addr_next;
  logic          mem_req_next;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] head_data;
  logic          mismatch;
  logic          hit;
  logic          pop;
  logic          push;
  logic          can_issue;

  // Entry i implicitly holds the word at head_addr + i*STEP.
  assign mismatch  = (cpu_addr != head_addr);
  assign hit       = !mismatch && (fifo_count != '0);
  assign pop       = hit && cpu_en;
  assign can_issue = (fifo_count < CW'(DEPTH));
  assign cpu_ready = hit;
  assign cpu_data  = hit ? head_data : DW'(IFB_NOP);

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (mismatch),
    .wdata (mem_rdata),
    .rdata (head_data),
    .count (fifo_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IFB_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IFB_IDLE:  if (mismatch || can_issue) state_next = IFB_FETCH;
      IFB_FETCH: begin
        if (mismatch && !mem_ack)      state_next = IFB_DRAIN;
        else if (mem_ack && !mismatch) state_next = IFB_IDLE;
      end
      IFB_DRAIN: if (mem_ack) state_next = IFB_FETCH;
      default:   state_next = IFB_IDLE;
    endcase
  end

  // A flush retargets both pointers; any new issue uses the retargeted fetch address.
  always_comb begin
    push            = 1'b0;
    mem_req_next    = mem_req;
    mem_addr_next   = mem_addr;
    head_addr_next  = head_addr;
    fetch_addr_next = fetch_addr;
    if (pop) head_addr_next = head_addr + STEP;
    if (mismatch) begin
      head_addr_next  = cpu_addr;
      fetch_addr_next = cpu_addr;
    end
    case (state)
      IFB_IDLE: begin
        if (mismatch || can_issue) begin
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_addr_next;
        end
      end
      IFB_FETCH: begin
        if (mem_ack) begin
          if (mismatch) begin
            mem_req_next  = 1'b1;
            mem_addr_next = fetch_addr_next;
          end else begin
            push            = 1'b1;
            fetch_addr_next = fetch_addr + STEP;
            mem_req_next    = 1'b0;
          end
        end
      end
      IFB_DRAIN: begin
        if (mem_ack) begin
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_addr_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_addr  <= '0;
      fetch_addr <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      head_addr  <= head_addr_next;
      fetch_addr <= fetch_addr_next;
      mem_req    <= mem_req_next;
      mem_addr   <= mem_addr_next;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Saturating hit/miss counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (pop && (hit_q != 32'hFFFF_FFFF))                  hit_q  <= hit_q + 32'd1;
      if (mismatch && cpu_en && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Scoreboard bench for ifetch_prefetch_buf: behavioural memory with programmable ack
// latency, expected CPU words queued as the PC is driven and checked when delivered.
module tb_ifetch_prefetch_buf;

  logic        clock;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_en;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int          n_cmp;
  int          n_bad;
  int unsigned ack_delay;
  int unsigned rsp_cnt;
  logic [31:0] pc;
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];

  ifetch_prefetch_buf u_dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_en    (cpu_en),
    .cpu_data  (cpu_data),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: ack in the (ack_delay+1)-th cycle a request is visible.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    rsp_cnt   = 0;
    forever begin
      @(posedge clock); #1;
      if (!reset) begin
        mem_ack = 1'b0;
        rsp_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          rsp_cnt = 1;
          req_log.push_back(mem_addr);
        end else begin
          rsp_cnt = 0;
        end
      end else if (mem_req) begin
        if (rsp_cnt == 0) req_log.push_back(mem_addr);
        if (rsp_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = memf(mem_addr);
        end else begin
          rsp_cnt++;
        end
      end
    end
  end

  task automatic step(input logic [31:0] a, input logic en);
    @(posedge clock); #1;
    cpu_addr = a;
    cpu_en   = en;
    #1;
  endtask

  task automatic branch(input logic [31:0] a);
    pc = a;
    exp_q.delete();
    exp_q.push_back(memf(a));
  endtask

  // CPU consumes n sequential words, advancing only when the fetch port is ready.
  task automatic run_stream(input int n);
    int got;
    got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      step(pc, 1'b1);
      if (cpu_ready) begin
        check("stream_data", cpu_data, exp_q.pop_front());
        pc = pc + 32'd1;
        exp_q.push_back(memf(pc));
        got++;
      end
    end
    if (got < n) check("stream_timeout", 64'(got), 64'(n));
  endtask

  task automatic wait_full(input logic [31:0] a, input string tag);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      step(a, 1'b0);
      if (u_dut.fifo_count == 3'd4 && !mem_req) done = 1'b1;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    logic seen;
    int   base;
    n_cmp     = 0;
    n_bad     = 0;
    ack_delay = 1;
    reset     = 1'b0;
    cpu_en    = 1'b0;
    branch(32'd0);
    cpu_addr  = pc;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_data", cpu_data, 32'd0);
    check("rst_count", u_dut.fifo_count, 3'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);

    // Reset release: first issue, first word two edges later, then fill
    @(negedge clock);
    reset = 1'b1;
    step(32'd0, 1'b0);
    check("first_req", mem_req, 1'b1);
    check("first_addr", mem_addr, 32'd0);
    check("first_ready_lo", cpu_ready, 1'b0);
    step(32'd0, 1'b0);
    check("first_ready_lo2", cpu_ready, 1'b0);
    step(32'd0, 1'b0);
    check("first_ready_hi", cpu_ready, 1'b1);
    check("first_data", cpu_data, exp_q[0]);
    wait_full(32'd0, "fill_done");
    check("fill_count", u_dut.fifo_count, 3'd4);
    check("fill_log_size", 64'(req_log.size()), 64'd4);

    // Steady stream: consume 0..3 then refill 4..7
    run_stream(4);
    wait_full(pc, "refill_done");
    check("refill_log_size", 64'(req_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < req_log.size(); i++)
      check("seq_addr", req_log[i], 64'(i));

    // Branch to 0x20 from a full buffer holding 4..7
    branch(32'h20);
    step(pc, 1'b1);
    check("br_ready_lo", cpu_ready, 1'b0);
    check("br_nop", cpu_data, 32'd0);
    step(pc, 1'b1);
    check("br_count", u_dut.fifo_count, 3'd0);
    check("br_req", mem_req, 1'b1);
    check("br_addr", mem_addr, 32'h20);
    check("br_ready_c1", cpu_ready, 1'b0);
    step(pc, 1'b1);
    check("br_ready_c2", cpu_ready, 1'b0);
    step(pc, 1'b1);
    check("br_ready_c3", cpu_ready, 1'b1);
    check("br_data", cpu_data, exp_q.pop_front());
    pc = pc + 32'd1;
    exp_q.push_back(memf(pc));
    run_stream(7);
    check("br_log_size_ok", 64'(req_log.size() >= 16), 64'd1);
    for (int i = 0; i < 8 && (8 + i) < req_log.size(); i++)
      check("br_seq_addr", req_log[8 + i], 64'(32'h20 + i));

    // Flush while a slow request for word 5 is outstanding
    ack_delay = 3;
    branch(32'd1);
    step(pc, 1'b0);
    wait_full(pc, "slow_fill_done");
    step(pc, 1'b1);
    check("slow_ready", cpu_ready, 1'b1);
    check("slow_data", cpu_data, exp_q.pop_front());
    pc = pc + 32'd1;
    exp_q.push_back(memf(pc));
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(pc, 1'b0);
      if (mem_req && mem_addr == 32'd5) seen = 1'b1;
    end
    check("req5_seen", seen, 1'b1);
    branch(32'h40);
    step(pc, 1'b1);
    check("drain_req", mem_req, 1'b1);
    check("drain_addr", mem_addr, 32'd5);
    check("drain_ready", cpu_ready, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(pc, 1'b0);
      if (mem_addr != 32'd5) break;
      check("drain_hold_req", mem_req, 1'b1);
      check("drain_hold_ready", cpu_ready, 1'b0);
    end
    check("retarget_req", mem_req, 1'b1);
    check("retarget_addr", mem_addr, 32'h40);
    base = req_log.size();
    check("retarget_log_prev", (base >= 2) ? req_log[base - 2] : 32'hFFFF_FFFF, 32'd5);
    check("retarget_log_last", (base >= 1) ? req_log[base - 1] : 32'hFFFF_FFFF, 32'h40);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(pc, 1'b0);
      if (cpu_ready) seen = 1'b1;
    end
    check("retarget_ready", seen, 1'b1);
    check("retarget_data", cpu_data, exp_q.pop_front());

    // Asynchronous reset while a request is in flight
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(pc, 1'b0);
      if (mem_req) seen = 1'b1;
    end
    check("arst_in_fetch", seen, 1'b1);
    check("arst_pre_ready", cpu_ready, 1'b1);
    reset = 1'b0;
    #1;
    check("arst_req", mem_req, 1'b0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_ready", cpu_ready, 1'b0);
    check("arst_count", u_dut.fifo_count, 3'd0);

    // Six hits then one branch with cpu_en high
    repeat (2) @(posedge clock);
    ack_delay = 1;
    branch(32'd0);
    cpu_addr = pc;
    cpu_en   = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wait_full(pc, "perf_fill_done");
    run_stream(6);
    branch(32'h20);
    step(pc, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(pc, 1'b0);
      if (cpu_ready) seen = 1'b1;
    end
    check("perf_br_ready", seen, 1'b1);
    check("perf_br_data", cpu_data, exp_q[0]);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_hit_cnt", hit_cnt, 32'd6);
    check("perf_miss_cnt", miss_cnt, 32'd1);
`else
    check("perf_hit_cnt", hit_cnt, 32'd0);
    check("perf_miss_cnt", miss_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
